// File: rtl/bus_demux_regbank.sv
// Destination side of the common bus: eight registers updated by LOAD/INC/CLR commands
// under a valid/ready handshake with a one-cycle turnaround. Optional readback: BUS_DEMUX_READBACK_EN.
module bus_demux_regbank #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] BUS_IN,
    input  logic [2:0]       DEST,
    input  logic [1:0]       OP,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    output logic [WIDTH-1:0] REG_OUT [0:7],
    output logic [7:0]       LD_STROBE,
    output logic             WRAP
`ifdef BUS_DEMUX_READBACK_EN
    ,
    input  logic [2:0]       RD_SEL,
    output logic [WIDTH-1:0] RD_DATA
`endif
);

    localparam int unsigned NUM_REGS = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TURN = 1'b1;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [0:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic [7:0]       strobe_q, strobe_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             accept_c;

    // Handshake FSM and register-bank next state
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        strobe_d = '0;
        wrap_d   = 1'b0;
        accept_c = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (CMD_VALID) begin
                    accept_c = 1'b1;
                    state_d  = ST_TURN;
                    ready_d  = 1'b0;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        for (int i = 0; i < NUM_REGS; i++) begin
            if (accept_c && (DEST == 3'(i))) begin
                case (OP)
                    OP_LOAD: begin
                        regs_d[i]   = BUS_IN;
                        strobe_d[i] = 1'b1;
                    end
                    OP_INC: begin
                        regs_d[i]   = regs_q[i] + WIDTH'(1);
                        strobe_d[i] = 1'b1;
                        wrap_d      = &regs_q[i];
                    end
                    OP_CLR: begin
                        regs_d[i]   = '0;
                        strobe_d[i] = 1'b1;
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end
        end
    end

    // State register; reset discards any command presented in the same cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            strobe_q <= '0;
            wrap_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            strobe_q <= strobe_d;
            wrap_q   <= wrap_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef BUS_DEMUX_READBACK_EN
    logic [WIDTH-1:0] rd_data_q;

    // Reading from the next-state bank gives write-first bypass for free
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data_q <= RESET_VALUE;
        end else begin
            rd_data_q <= regs_d[RD_SEL];
        end
    end

    assign RD_DATA = rd_data_q;
`endif

    assign CMD_READY = ready_q;
    assign LD_STROBE = strobe_q;
    assign WRAP      = wrap_q;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            REG_OUT[i] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_bus_demux_regbank.sv
// Scoreboarded directed test of bus_demux_regbank: default instance (RESET_VALUE=0)
// and a second instance with RESET_VALUE=0x1234.
module tb_bus_demux_regbank;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] LD  = 2'b01;
    localparam logic [1:0] INC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    typedef struct packed {
        logic        sel;
        logic        rst;
        logic        valid;
        logic [1:0]  op;
        logic [2:0]  dest;
        logic [15:0] bus;
        logic [2:0]  rdsel;
        logic        eset;
        logic [2:0]  eidx;
        logic [15:0] eval;
        logic        erdy;
        logic [7:0]  estb;
        logic        ewrap;
        logic [15:0] erd;
    } vec_t;

    typedef struct packed {
        int              due;
        logic            sel;
        logic [7:0][15:0] regs;
        logic            rdy;
        logic [7:0]      stb;
        logic            wrap;
        logic [15:0]     rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic [1:0]  op0 = NOP, op1 = NOP;
    logic [2:0]  dest0 = '0, dest1 = '0;
    logic [15:0] bus0 = '0, bus1 = '0;
    logic [2:0]  rdsel0 = '0, rdsel1 = '0;
    logic        rdy0, rdy1, wrap0, wrap1;
    logic [7:0]  stb0, stb1;
    logic [15:0] regs0 [0:7];
    logic [15:0] regs1 [0:7];
    logic [15:0] rd0, rd1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];
    logic [7:0][15:0] img0, img1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_demux_regbank u_dut0 (
        .CLK(clk), .RESET(rst0), .BUS_IN(bus0), .DEST(dest0), .OP(op0),
        .CMD_VALID(valid0), .CMD_READY(rdy0), .REG_OUT(regs0),
        .LD_STROBE(stb0), .WRAP(wrap0)
`ifdef BUS_DEMUX_READBACK_EN
        , .RD_SEL(rdsel0), .RD_DATA(rd0)
`endif
    );

    bus_demux_regbank #(.WIDTH(16), .RESET_VALUE(16'h1234)) u_dut1 (
        .CLK(clk), .RESET(rst1), .BUS_IN(bus1), .DEST(dest1), .OP(op1),
        .CMD_VALID(valid1), .CMD_READY(rdy1), .REG_OUT(regs1),
        .LD_STROBE(stb1), .WRAP(wrap1)
`ifdef BUS_DEMUX_READBACK_EN
        , .RD_SEL(rdsel1), .RD_DATA(rd1)
`endif
    );

`ifndef BUS_DEMUX_READBACK_EN
    assign rd0 = '0;
    assign rd1 = '0;
`endif

    function automatic vec_t mk(logic sel, logic rst, logic valid, logic [1:0] op,
                                logic [2:0] dest, logic [15:0] bus, logic [2:0] rdsel,
                                logic eset, logic [2:0] eidx, logic [15:0] eval,
                                logic erdy, logic [7:0] estb, logic ewrap, logic [15:0] erd);
        vec_t v;
        v.sel = sel; v.rst = rst; v.valid = valid; v.op = op; v.dest = dest;
        v.bus = bus; v.rdsel = rdsel; v.eset = eset; v.eidx = eidx; v.eval = eval;
        v.erdy = erdy; v.estb = estb; v.ewrap = ewrap; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one vector and queue the response expected after the sampling edge
    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        if (v.sel == 1'b0) begin
            rst0 = v.rst; valid0 = v.valid; op0 = v.op; dest0 = v.dest;
            bus0 = v.bus; rdsel0 = v.rdsel;
            if (v.rst) img0 = '0;
            if (v.eset) img0[v.eidx] = v.eval;
            e.regs = img0;
        end else begin
            rst1 = v.rst; valid1 = v.valid; op1 = v.op; dest1 = v.dest;
            bus1 = v.bus; rdsel1 = v.rdsel;
            if (v.rst) img1 = {8{16'h1234}};
            if (v.eset) img1[v.eidx] = v.eval;
            e.regs = img1;
        end
        e.due  = cyc + 1;
        e.sel  = v.sel;
        e.rdy  = v.erdy;
        e.stb  = v.estb;
        e.wrap = v.ewrap;
        e.rd   = v.erd;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs when the queued response falls due
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            logic [7:0][15:0] act;
            e = exp_q.pop_front();
            for (int i = 0; i < 8; i++) act[i] = e.sel ? regs1[i] : regs0[i];
            chk(e.sel ? "dut1.REG_OUT" : "dut0.REG_OUT", 128'(act), 128'(e.regs));
            chk(e.sel ? "dut1.CMD_READY" : "dut0.CMD_READY", 128'(e.sel ? rdy1 : rdy0), 128'(e.rdy));
            chk(e.sel ? "dut1.LD_STROBE" : "dut0.LD_STROBE", 128'(e.sel ? stb1 : stb0), 128'(e.stb));
            chk(e.sel ? "dut1.WRAP" : "dut0.WRAP", 128'(e.sel ? wrap1 : wrap0), 128'(e.wrap));
`ifdef BUS_DEMUX_READBACK_EN
            chk(e.sel ? "dut1.RD_DATA" : "dut0.RD_DATA", 128'(e.sel ? rd1 : rd0), 128'(e.rd));
`endif
        end
    end

    initial begin
        img0 = '0;
        img1 = {8{16'h1234}};
        //           sel rst vld op   dst   bus       rds   set idx   val       rdy stb       wrp rd
        // Reset held two cycles with a LOAD pending
        vecs.push_back(mk(0, 1, 1, LD,  3'd1, 16'hAAAA, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 1, LD,  3'd1, 16'hAAAA, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        // Single LOAD and turnaround
        vecs.push_back(mk(0, 0, 1, LD,  3'd3, 16'hBEEF, 3'd2, 1, 3'd3, 16'hBEEF, 0, 8'h08, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        // VALID held for four cycles: only the 1st and 3rd are accepted
        vecs.push_back(mk(0, 0, 1, LD,  3'd0, 16'h1111, 3'd2, 1, 3'd0, 16'h1111, 0, 8'h01, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, LD,  3'd1, 16'h2222, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, LD,  3'd2, 16'h3333, 3'd2, 1, 3'd2, 16'h3333, 0, 8'h04, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 1, LD,  3'd3, 16'h4444, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h3333));
        // INC wrap then plain INC
        vecs.push_back(mk(0, 0, 1, LD,  3'd5, 16'hFFFF, 3'd2, 1, 3'd5, 16'hFFFF, 0, 8'h20, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 1, INC, 3'd5, 16'h7777, 3'd2, 1, 3'd5, 16'h0000, 0, 8'h20, 1, 16'h3333));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 1, INC, 3'd5, 16'h0000, 3'd2, 1, 3'd5, 16'h0001, 0, 8'h20, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h3333));
        // NOP still completes the handshake
        vecs.push_back(mk(0, 0, 1, NOP, 3'd4, 16'hFFFF, 3'd2, 0, 3'd0, 16'h0000, 0, 8'h00, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h3333));
        // CLR
        vecs.push_back(mk(0, 0, 1, CLR, 3'd0, 16'h5555, 3'd2, 1, 3'd0, 16'h0000, 0, 8'h01, 0, 16'h3333));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h3333));
        // Readback bypass, then reset in the turnaround cycle
        vecs.push_back(mk(0, 0, 1, LD,  3'd2, 16'h00A5, 3'd2, 1, 3'd2, 16'h00A5, 0, 8'h04, 0, 16'h00A5));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd3, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'hBEEF));
        vecs.push_back(mk(0, 0, 1, LD,  3'd6, 16'h5A5A, 3'd6, 1, 3'd6, 16'h5A5A, 0, 8'h40, 0, 16'h5A5A));
        vecs.push_back(mk(0, 1, 1, INC, 3'd6, 16'h0000, 3'd6, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, NOP, 3'd0, 16'h0000, 3'd3, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        // Instance with RESET_VALUE = 0x1234
        vecs.push_back(mk(1, 1, 0, NOP, 3'd0, 16'h0000, 3'd0, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h1234));
        vecs.push_back(mk(1, 0, 1, CLR, 3'd7, 16'hFFFF, 3'd7, 1, 3'd7, 16'h0000, 0, 8'h80, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, NOP, 3'd0, 16'h0000, 3'd7, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 1, NOP, 3'd2, 16'hDEAD, 3'd2, 0, 3'd0, 16'h0000, 0, 8'h00, 0, 16'h1234));
        vecs.push_back(mk(1, 0, 0, NOP, 3'd0, 16'h0000, 3'd2, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h1234));
        vecs.push_back(mk(1, 0, 1, INC, 3'd1, 16'h0000, 3'd1, 1, 3'd1, 16'h1235, 0, 8'h02, 0, 16'h1235));
        vecs.push_back(mk(1, 0, 0, NOP, 3'd0, 16'h0000, 3'd1, 0, 3'd0, 16'h0000, 1, 8'h00, 0, 16'h1235));

        foreach (vecs[k]) drive(vecs[k]);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
